// File: rtl/cmn_val_rdy_demux.sv
`default_nettype none
// ============================================================================
//  Module      : cmn_val_rdy_demux
//  Description : Steers one val/rdy message stream to one of p_noutputs
//                val/rdy output streams, selected per message by in_sel_i.
//                Each output owns a one-entry registered slot, so a stalled
//                output only blocks messages that target it.
//  Ports       : clk          clock, all state changes on posedge
//                reset        asynchronous active-high reset
//                in_val_i     input message valid
//                in_rdy_o     input ready (combinational)
//                in_msg_i     input message
//                in_sel_i     destination index, qualified by in_val_i
//                out_val_o    per-output valid, bit i = output i
//                out_rdy_i    per-output ready
//                out_msg_o    output i occupies [i*p_nbits +: p_nbits]
//                err_o        sticky, set when a message had in_sel_i >= p_noutputs
//  Revision    : 1.0 - initial release
// ============================================================================
module cmn_val_rdy_demux #(
   parameter int p_nbits    = 32,
   parameter int p_noutputs = 4,
   parameter int p_pipe     = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_val_i,
   output logic                                in_rdy_o,
   input  logic [p_nbits-1:0]                  in_msg_i,
   input  logic [$clog2(p_noutputs)-1:0]       in_sel_i,
   output logic [p_noutputs-1:0]               out_val_o,
   input  logic [p_noutputs-1:0]               out_rdy_i,
   output logic [p_noutputs*p_nbits-1:0]       out_msg_o,
   output logic                                err_o
);

   localparam int   c_SW   = $clog2(p_noutputs);
   localparam logic c_PIPE = (p_pipe != 0);

   logic [p_noutputs-1:0]         full_q;
   logic [p_noutputs-1:0]         full_d;
   logic [p_noutputs*p_nbits-1:0] msg_q;
   logic                          err_q;
   logic                          err_d;

   logic [p_noutputs-1:0]         w_sel_oh;
   logic [p_noutputs-1:0]         w_room;
   logic [p_noutputs-1:0]         w_enq_oh;
   logic [p_noutputs-1:0]         w_deq;
   logic                          w_sel_ok;
   logic                          w_enq;

   // One-hot decode of the destination. An out-of-range select decodes to
   // all zeros, which both flags the error and keeps every slot untouched.
   always_comb begin
      w_sel_oh = '0;
      for (int i = 0; i < p_noutputs; i++) begin
         w_sel_oh[i] = (in_sel_i == c_SW'(i));
      end
   end

   assign w_sel_ok = |w_sel_oh;

   // A slot has room when empty, or (pipelined variant only) when it is
   // being drained this same cycle.
   assign w_room   = ~full_q | (out_rdy_i & {p_noutputs{c_PIPE}});

   // Out-of-range messages are always accepted so they can be discarded.
   assign in_rdy_o = ~w_sel_ok | (|(w_sel_oh & w_room));

   assign w_enq    = in_val_i & in_rdy_o;
   assign w_enq_oh = w_sel_oh & {p_noutputs{w_enq}};
   assign w_deq    = full_q & out_rdy_i;

   // Enqueue wins over dequeue so a simultaneous drain+refill stays full.
   assign full_d   = (full_q & ~w_deq) | w_enq_oh;
   assign err_d    = err_q | (w_enq & ~w_sel_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= '0;
         err_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         err_q  <= err_d;
      end
   end

   // Per-slot payload register, written only when that slot enqueues.
   generate
      for (genvar g = 0; g < p_noutputs; g++) begin : g_slot
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               msg_q[g*p_nbits +: p_nbits] <= '0;
            end else if (w_enq_oh[g]) begin
               msg_q[g*p_nbits +: p_nbits] <= in_msg_i;
            end
         end
      end
   endgenerate

   assign out_val_o = full_q;
   assign out_msg_o = msg_q;
   assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmn_val_rdy_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmn_val_rdy_demux
//  Description : Scoreboard bench for cmn_val_rdy_demux. Instance A is the
//                4-output pipelined variant, instance B the 3-output
//                non-pipelined variant (covers out-of-range select).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmn_val_rdy_demux;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance A: 4 outputs, 32 bits, pipelined ------------
   logic          a_in_val;
   logic          a_in_rdy;
   logic [31:0]   a_in_msg;
   logic [1:0]    a_in_sel;
   logic [3:0]    a_out_val;
   logic [3:0]    a_out_rdy;
   logic [127:0]  a_out_msg;
   logic          a_err;

   cmn_val_rdy_demux #(.p_nbits(32), .p_noutputs(4), .p_pipe(1)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_val_i  (a_in_val),
      .in_rdy_o  (a_in_rdy),
      .in_msg_i  (a_in_msg),
      .in_sel_i  (a_in_sel),
      .out_val_o (a_out_val),
      .out_rdy_i (a_out_rdy),
      .out_msg_o (a_out_msg),
      .err_o     (a_err)
   );

   // ---------------- instance B: 3 outputs, 16 bits, not pipelined ---------
   logic          b_in_val;
   logic          b_in_rdy;
   logic [15:0]   b_in_msg;
   logic [1:0]    b_in_sel;
   logic [2:0]    b_out_val;
   logic [2:0]    b_out_rdy;
   logic [47:0]   b_out_msg;
   logic          b_err;

   cmn_val_rdy_demux #(.p_nbits(16), .p_noutputs(3), .p_pipe(0)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_val_i  (b_in_val),
      .in_rdy_o  (b_in_rdy),
      .in_msg_i  (b_in_msg),
      .in_sel_i  (b_in_sel),
      .out_val_o (b_out_val),
      .out_rdy_i (b_out_rdy),
      .out_msg_o (b_out_msg),
      .err_o     (b_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model A: per-output in-order FIFOs ----------
   // A slot holds at most one message, so the number of undelivered messages
   // per output is 0 or 1; the FIFO form also catches loss and duplication.
   logic [31:0] afifo [4][16];
   int          awp [4];
   int          arp [4];
   logic        a_pend = 1'b0;
   logic [1:0]  a_psel;
   logic [31:0] a_pmsg;

   // ---------------- reference model B: only output 0 and errors used ------
   logic [15:0] bq [$];
   logic        b_pend = 1'b0;
   logic [1:0]  b_psel;
   logic [15:0] b_pmsg;
   logic        b_exp_err = 1'b0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         awp[i] = 0;
         arp[i] = 0;
      end
   end

   // Stimulus side: note accepted messages, commit them on the next edge.
   always @(negedge clk) begin
      a_pend = !reset && a_in_val && a_in_rdy;
      a_psel = a_in_sel;
      a_pmsg = a_in_msg;
      b_pend = !reset && b_in_val && b_in_rdy;
      b_psel = b_in_sel;
      b_pmsg = b_in_msg;
   end

   always @(posedge clk) begin
      if (a_pend && !reset) begin
         afifo[a_psel][awp[a_psel] & 15] = a_pmsg;
         awp[a_psel]++;
      end
      if (b_pend && !reset) begin
         if (b_psel == 2'd0)      bq.push_back(b_pmsg);
         else if (b_psel >= 2'd3) b_exp_err = 1'b1;
      end
      a_pend = 1'b0;
      b_pend = 1'b0;
   end

   // Output monitor A
   always @(negedge clk) begin : a_out_mon
      int cnt;
      if (!reset) begin
         cnt = awp[a_in_sel] - arp[a_in_sel];
         chk("a_in_rdy", a_in_rdy, (cnt == 0) || a_out_rdy[a_in_sel]);
         for (int i = 0; i < 4; i++) begin
            cnt = awp[i] - arp[i];
            chk("a_out_val", a_out_val[i], cnt > 0);
            if (cnt > 0 && a_out_val[i]) begin
               chk("a_out_msg", a_out_msg[i*32 +: 32], afifo[i][arp[i] & 15]);
               if (a_out_rdy[i]) arp[i]++;
            end
         end
         chk("a_err", a_err, 1'b0);
      end
   end

   // Output monitor B
   always @(negedge clk) begin : b_out_mon
      logic exp_rdy;
      if (!reset) begin
         if (b_in_sel >= 2'd3)      exp_rdy = 1'b1;
         else if (b_in_sel == 2'd0) exp_rdy = (bq.size() == 0);
         else                       exp_rdy = 1'b1;
         chk("b_in_rdy", b_in_rdy, exp_rdy);
         chk("b_out_val0", b_out_val[0], bq.size() > 0);
         if (bq.size() > 0 && b_out_val[0]) begin
            chk("b_out_msg0", b_out_msg[15:0], bq[0]);
            if (b_out_rdy[0]) void'(bq.pop_front());
         end
         chk("b_out_val12", b_out_val[2:1], 2'b00);
         chk("b_err", b_err, b_exp_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_send(input logic [1:0] sel, input logic [31:0] msg, output int cyc);
      a_in_val = 1'b1;
      a_in_sel = sel;
      a_in_msg = msg;
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         logic acc;
         @(negedge clk);
         acc = a_in_rdy;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            a_in_val = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL a_send_timeout actual=no_accept required=accept_within_100");
      a_in_val = 1'b0;
   endtask

   task automatic b_send(input logic [1:0] sel, input logic [15:0] msg, output int cyc);
      b_in_val = 1'b1;
      b_in_sel = sel;
      b_in_msg = msg;
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         logic acc;
         @(negedge clk);
         acc = b_in_rdy;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            b_in_val = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL b_send_timeout actual=no_accept required=accept_within_100");
      b_in_val = 1'b0;
   endtask

   initial begin
      int cyc;
      int total;
      a_in_val  = 1'b0; a_in_msg = '0; a_in_sel = '0; a_out_rdy = '0;
      b_in_val  = 1'b0; b_in_msg = '0; b_in_sel = '0; b_out_rdy = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_a_out_val", a_out_val, 4'h0);
      chk("rst_a_out_msg", a_out_msg, 128'h0);
      chk("rst_a_err",     a_err, 1'b0);
      chk("rst_a_in_rdy",  a_in_rdy, 1'b1);
      chk("rst_b_out_val", b_out_val, 3'h0);
      chk("rst_b_err",     b_err, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Route to each output
      a_out_rdy = 4'hF;
      for (int i = 0; i < 4; i++) begin
         a_send(2'(i), 32'hA0 + 32'(i), cyc);
         chk("t1_accept_cycles", 32'(cyc), 32'd1);
      end
      repeat (3) tick();

      // Stall isolation on output 2
      a_out_rdy = 4'b1011;
      a_send(2'd2, 32'h11, cyc);
      chk("t2_first_accept", 32'(cyc), 32'd1);
      fork
         a_send(2'd2, 32'h22, cyc);
         begin
            repeat (3) tick();
            a_out_rdy = 4'hF;
         end
      join
      chk("t2_hold_cycles", 32'(cyc), 32'd4);
      a_send(2'd1, 32'h33, cyc);
      chk("t2_after_drain", 32'(cyc), 32'd1);
      repeat (3) tick();

      // Back-to-back to one output, pipelined
      a_out_rdy = 4'hF;
      total = 0;
      for (int k = 0; k < 8; k++) begin
         a_send(2'd0, 32'hC0 + 32'(k), cyc);
         total += cyc;
      end
      chk("t3_pipe_cycles", 32'(total), 32'd8);
      repeat (3) tick();

      // Same stimulus, non-pipelined: one message every two cycles
      b_out_rdy = 3'h7;
      total = 0;
      for (int k = 0; k < 8; k++) begin
         b_send(2'd0, 16'hB0 + 16'(k), cyc);
         total += cyc;
      end
      chk("t3_nopipe_cycles", 32'(total), 32'd15);
      repeat (3) tick();

      // Out-of-range select is accepted, dropped, flags sticky error
      b_send(2'd3, 16'hDEAD, cyc);
      chk("t4_oor_accept", 32'(cyc), 32'd1);
      repeat (3) tick();
      chk("t4_err_sticky", b_err, 1'b1);
      b_send(2'd0, 16'h0BEE, cyc);
      chk("t4_route_after", 32'(cyc), 32'd1);
      repeat (3) tick();

      // Asynchronous reset between edges with slots full
      a_out_rdy = 4'h0;
      a_send(2'd0, 32'h50, cyc);
      a_send(2'd1, 32'h51, cyc);
      #1 reset = 1'b1;
      #1;
      chk("t5_out_val", a_out_val, 4'h0);
      chk("t5_out_msg", a_out_msg, 128'h0);
      chk("t5_a_err",   a_err, 1'b0);
      chk("t5_b_err",   b_err, 1'b0);
      for (int i = 0; i < 4; i++) begin
         awp[i] = 0;
         arp[i] = 0;
      end
      a_pend = 1'b0;
      b_pend = 1'b0;
      bq.delete();
      b_exp_err = 1'b0;
      #1 reset = 1'b0;
      tick();
      a_out_rdy = 4'hF;
      a_send(2'd1, 32'h61, cyc);
      a_send(2'd3, 32'h63, cyc);
      repeat (3) tick();

      // Random traffic
      for (int n = 0; n < 10000; n++) begin
         logic acc;
         if (!a_in_val && ($urandom_range(0, 3) != 0)) begin
            a_in_val = 1'b1;
            a_in_sel = 2'($urandom_range(0, 3));
            a_in_msg = $urandom;
         end
         a_out_rdy = 4'($urandom_range(0, 15));
         @(negedge clk);
         acc = a_in_val && a_in_rdy;
         @(posedge clk);
         #1;
         if (acc) a_in_val = 1'b0;
      end
      a_in_val  = 1'b0;
      a_out_rdy = 4'hF;
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
         chk("t6_drained", 32'(awp[i] - arp[i]), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
